// File: rtl/alu_mdu_exec.sv
// alu_mdu_exec: registered EX-stage ALU with iterative multiply/divide into HI/LO.
// Single-cycle ops answer the cycle after accept; mult/div hold off issue for
// WIDTH iterations plus one fix-up cycle before the HI/LO write.
module alu_mdu_exec #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);
  localparam logic [WIDTH-1:0]   ALL1 = '1;
  localparam logic [SHW-1:0]     LAST = SHW'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + ONE2;
  endfunction

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_q, a_d;         // raw dividend, returned as HI on divide-by-zero
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d, ill_q, ill_d, ov_q, ov_d;

  op_e              op;
  logic [WIDTH-1:0] sc_res;
  logic             accept, is_mul, is_div, sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fin_hi, fin_lo;

  // decode ALUOp, falling through to funct for R-type
  always_comb begin
    op = OP_ILL;
    case (alu_op)
      4'b0000: op = OP_ADD;
      4'b0001: op = OP_SUB;
      4'b0011: op = OP_AND;
      4'b0100: op = OP_OR;
      4'b0101: op = OP_XOR;
      4'b0110: op = OP_SLT;
      4'b0010: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b101011: op = OP_SLTU;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b000011: op = OP_SRA;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011000: op = OP_MULT;
          6'b011001: op = OP_MULTU;
          6'b011010: op = OP_DIV;
          6'b011011: op = OP_DIVU;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // single-cycle result; illegal ops yield zero
  always_comb begin
    sc_res = '0;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  sc_res = b << shamt;
      OP_SRL:  sc_res = b >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(b) >>> shamt);
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag  = (sgn && a[WIDTH-1]) ? neg_w(a) : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? neg_w(b) : b;

  // one shift-add step: add multiplicand on LSB, shift the pair right
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // one restoring step: shift next dividend bit into remainder, trial subtract
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_sub  = div_sh - {1'b0, opnd_q};
  assign div_rem  = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // sign fix-up; a zero divisor bypasses it so HI returns the raw dividend
  assign prod_fix = neg_q  ? neg_2w(acc_q) : acc_q;
  assign quo_fix  = neg_q  ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  assign fin_hi   = div_q ? (dz_q ? a_q  : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign fin_lo   = div_q ? (dz_q ? ALL1 : quo_fix) : prod_fix[WIDTH-1:0];

  // next state and datapath: issue, iterate, fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    ov_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? S_MUL : S_DIV;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
            opnd_d  = is_mul ? a_mag : b_mag;
            a_d     = a;
            div_d   = is_div;
            neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = sgn && a[WIDTH-1];
            dz_d    = (b == '0);
          end else begin
            ov_d   = 1'b1;
            res_d  = sc_res;
            zero_d = (sc_res == '0);
            ill_d  = (op == OP_ILL);
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end
      end
      S_FIN: begin
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        ov_d    = 1'b1;
        res_d   = fin_lo;
        zero_d  = (fin_lo == '0);
        ill_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // datapath and output registers; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      a_q    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      a_q    <= a_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      ill_q  <= ill_d;
      ov_q   <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_alu_mdu_exec.sv
// Directed bench for alu_mdu_exec: table of single-cycle vectors plus
// hand-written multiply/divide, stall, reset-abort and WIDTH=8 sequences.
module tb_alu_mdu_exec;
  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        out_valid, zero, illegal, busy;
  logic [31:0] result, hi, lo;

  logic        v8, rdy8, ov8, z8, il8, bsy8;
  logic [3:0]  op8;
  logic [5:0]  fn8;
  logic [7:0]  a8, b8, res8, hi8, lo8;
  logic [2:0]  sh8;

  int checks = 0;
  int errs   = 0;

  alu_mdu_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
    .hi(hi), .lo(lo), .busy(busy)
  );

  alu_mdu_exec #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .alu_op(op8), .funct(fn8), .a(a8), .b(b8), .shamt(sh8),
    .out_valid(ov8), .result(res8), .zero(z8), .illegal(il8),
    .hi(hi8), .lo(lo8), .busy(bsy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z, ill;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] va,
                      input logic [31:0] vb, input logic [4:0] sh, input logic [31:0] res,
                      input logic z, input logic ill);
    vec_t v;
    v.op = op; v.fn = fn; v.a = va; v.b = vb; v.sh = sh; v.res = res; v.z = z; v.ill = ill;
    vq.push_back(v);
  endtask

  // issue one mult/div on the 32-bit unit and check latency and HI/LO
  task automatic run_md(input string nm, input logic [5:0] fn, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    alu_op = 4'b0010; funct = fn; a = va; b = vb; shamt = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    chk({nm, " busy"}, 64'(busy), 64'(1));
    chk({nm, " in_ready"}, 64'(in_ready), 64'(0));
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(34));
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " result"}, 64'(result), 64'(elo));
    chk({nm, " illegal"}, 64'(illegal), 64'(0));
    chk({nm, " ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic run8(input string nm, input logic [5:0] fn, input logic [7:0] va,
                      input logic [7:0] vb, input logic [7:0] ehi, input logic [7:0] elo);
    int n;
    op8 = 4'b0010; fn8 = fn; a8 = va; b8 = vb; sh8 = '0; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    n = 1;
    while (!ov8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(10));
    chk({nm, " hi"}, 64'(hi8), 64'(ehi));
    chk({nm, " lo"}, 64'(lo8), 64'(elo));
  endtask

  initial begin
    int n, rdy_seen, pulses;
    reset = 1'b1; in_valid = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0; shamt = '0;
    v8 = 1'b0; op8 = '0; fn8 = '0; a8 = '0; b8 = '0; sh8 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst result", 64'(result), 64'(0));
    chk("rst zero", 64'(zero), 64'(0));
    chk("rst illegal", 64'(illegal), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst hi", 64'(hi), 64'(0));
    chk("rst lo", 64'(lo), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));

    //    op       funct      a             b             sh  result        z  ill
    addv(4'b0010, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 0);
    addv(4'b0010, 6'b100010, 32'd5,        32'd5,        0, 32'h00000000, 1, 0);
    addv(4'b0010, 6'b000011, 32'h0,        32'h80000000, 4, 32'hF8000000, 0, 0);
    addv(4'b0010, 6'b101011, 32'h1,        32'hFFFFFFFF, 0, 32'h00000001, 0, 0);
    addv(4'b0010, 6'b101010, 32'h1,        32'hFFFFFFFF, 0, 32'h00000000, 1, 0);
    addv(4'b0010, 6'b111111, 32'h12,       32'h34,       0, 32'h00000000, 1, 1);
    addv(4'b0000, 6'b000000, 32'd3,        32'd4,        0, 32'h00000007, 0, 0);
    addv(4'b0001, 6'b000000, 32'd3,        32'd4,        0, 32'hFFFFFFFF, 0, 0);
    addv(4'b0011, 6'b000000, 32'hF0F0,     32'hFF00,     0, 32'h0000F000, 0, 0);
    addv(4'b0100, 6'b000000, 32'hF0F0,     32'h0F00,     0, 32'h0000FFF0, 0, 0);
    addv(4'b0101, 6'b000000, 32'hFF,       32'h0F,       0, 32'h000000F0, 0, 0);
    addv(4'b0110, 6'b000000, 32'hFFFFFFFF, 32'h1,        0, 32'h00000001, 0, 0);
    addv(4'b0111, 6'b100000, 32'd1,        32'd1,        0, 32'h00000000, 1, 1);
    addv(4'b0010, 6'b100111, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 0, 0);
    addv(4'b0010, 6'b000000, 32'h0,        32'h1,        31, 32'h80000000, 0, 0);
    addv(4'b0010, 6'b000010, 32'h0,        32'h80000000, 4, 32'h08000000, 0, 0);
    addv(4'b0010, 6'b100110, 32'hAAAA5555, 32'hFFFF0000, 0, 32'h55555555, 0, 0);

    // back-to-back: in_valid stays high across the whole table
    for (int i = 0; i < vq.size(); i++) begin
      alu_op = vq[i].op; funct = vq[i].fn; a = vq[i].a; b = vq[i].b; shamt = vq[i].sh;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("vec%0d result", i), 64'(result), 64'(vq[i].res));
      chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vq[i].z));
      chk($sformatf("vec%0d illegal", i), 64'(illegal), 64'(vq[i].ill));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle out_valid", 64'(out_valid), 64'(0));
    chk("idle result hold", 64'(result), 64'(32'h55555555));

    run_md("mult", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

    alu_op = 4'b0010; funct = 6'b010000; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mfhi", 64'(result), 64'(32'hFFFFFFFF));
    funct = 6'b010010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mflo", 64'(result), 64'(32'hFFFFFFEB));

    // second op held on in_valid during a multu
    alu_op = 4'b0010; funct = 6'b011001; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    funct = 6'b100000; a = 32'd10; b = 32'd20;
    n = 1; rdy_seen = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      n++;
    end
    chk("hold ready low", 64'(rdy_seen), 64'(0));
    chk("hold latency", 64'(n), 64'(34));
    chk("hold multu lo", 64'(lo), 64'(6));
    chk("hold multu hi", 64'(hi), 64'(0));
    chk("hold pulse ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold add valid", 64'(out_valid), 64'(1));
    chk("hold add result", 64'(result), 64'(30));
    chk("hold add not busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("hold accepted once", 64'(pulses), 64'(0));

    run_md("div",      6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0",    6'b011011, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
    run_md("div mn",   6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    run_md("div s0",   6'b011010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_md("divu",     6'b011011, 32'd100,      32'd7,        32'd2,        32'd14);
    run_md("multu max",6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // reset ten cycles into a divide aborts it
    alu_op = 4'b0010; funct = 6'b011010; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort out_valid", 64'(out_valid), 64'(0));
    chk("abort hi", 64'(hi), 64'(0));
    chk("abort lo", 64'(lo), 64'(0));
    chk("abort in_ready", 64'(in_ready), 64'(1));
    chk("abort busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort no pulse", 64'(pulses), 64'(0));

    run8("w8 mult",  6'b011000, 8'h80, 8'h80, 8'h40, 8'h00);
    run8("w8 div mn",6'b011010, 8'h80, 8'hFF, 8'h00, 8'h80);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
